// File: rtl/usb_tx_nrzi_stuff_if.sv
// Serial bit handshake between the TX shift register and the USB line encoder.
// Latency: none, plain wires.
// Backpressure: d_ready is driven by the encoder and only pulses at bit boundaries.
interface usb_tx_nrzi_stuff_if;
  logic d_orig;
  logic d_valid;
  logic eop_req;
  logic d_ready;

  modport master (
    output d_orig,
    output d_valid,
    output eop_req,
    input  d_ready
  );

  modport slave (
    input  d_orig,
    input  d_valid,
    input  eop_req,
    output d_ready
  );
endinterface

// File: rtl/usb_tx_nrzi_stuff.sv
// USB full-speed TX line encoder: bit stuffing, NRZI, EOP generation, underrun flag.
// Latency: a bit taken at edge N drives the lines from edge N for CLKS_PER_BIT clocks.
// Backpressure: d_ready asserts only at a free bit boundary; a stuffed bit stalls one period.
module usb_tx_nrzi_stuff #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  usb_tx_nrzi_stuff_if.slave tx,
  output logic              d_plus,
  output logic              d_minus,
  output logic              tx_active,
  output logic              stuff_bit,
  output logic              eop_done,
  output logic              tx_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int EW = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;

  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);
  localparam logic [EW-1:0] SE0_LAST = EW'(EOP_SE0_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    EOP_SE0,
    EOP_J
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] bit_cnt, bit_cnt_nxt;
  logic [OW-1:0] ones_cnt, ones_nxt;
  logic [EW-1:0] se0_cnt, se0_nxt;
  logic          dp_nxt, dm_nxt;
  logic          active_nxt, stuff_nxt, done_nxt, err_nxt;
  logic          ready;
  logic          boundary;
  logic          nrzi_lvl;

  // While DATA is on the wire d_plus is the current NRZI level, so it doubles
  // as the encoder state; in IDLE it is J (1), which is the required start level.
  assign boundary = (state == IDLE) || (bit_cnt == BIT_LAST);
  assign nrzi_lvl = tx.d_orig ? d_plus : ~d_plus;
  assign tx.d_ready = ready;

  // Next-state, line levels and pulse decisions at each bit boundary.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = boundary ? '0 : bit_cnt + 1'b1;
    ones_nxt    = ones_cnt;
    se0_nxt     = se0_cnt;
    dp_nxt      = d_plus;
    dm_nxt      = d_minus;
    active_nxt  = tx_active;
    stuff_nxt   = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    ready       = 1'b0;

    case (state)
      IDLE: begin
        dp_nxt   = 1'b1;
        dm_nxt   = 1'b0;
        ones_nxt = '0;
        if (tx.d_valid) begin
          ready      = 1'b1;
          state_nxt  = DATA;
          active_nxt = 1'b1;
          dp_nxt     = nrzi_lvl;
          dm_nxt     = ~nrzi_lvl;
          ones_nxt   = tx.d_orig ? OW'(1) : '0;
        end
      end

      DATA: begin
        if (boundary) begin
          if (ones_cnt == ONES_MAX) begin
            // Stuffed zero: always a toggle, takes priority even over EOP so
            // the final run of ones is broken before SE0.
            stuff_nxt = 1'b1;
            ones_nxt  = '0;
            dp_nxt    = ~d_plus;
            dm_nxt    = d_plus;
          end else if (tx.eop_req) begin
            state_nxt = EOP_SE0;
            se0_nxt   = '0;
            ones_nxt  = '0;
            dp_nxt    = 1'b0;
            dm_nxt    = 1'b0;
          end else if (tx.d_valid) begin
            ready    = 1'b1;
            dp_nxt   = nrzi_lvl;
            dm_nxt   = ~nrzi_lvl;
            ones_nxt = tx.d_orig ? ones_cnt + 1'b1 : '0;
          end else begin
            // Underrun: nothing to send, abort the packet with an EOP.
            err_nxt   = 1'b1;
            state_nxt = EOP_SE0;
            se0_nxt   = '0;
            ones_nxt  = '0;
            dp_nxt    = 1'b0;
            dm_nxt    = 1'b0;
          end
        end
      end

      EOP_SE0: begin
        if (boundary) begin
          if (se0_cnt == SE0_LAST) begin
            state_nxt = EOP_J;
            dp_nxt    = 1'b1;
            dm_nxt    = 1'b0;
          end else begin
            se0_nxt = se0_cnt + 1'b1;
          end
        end
      end

      EOP_J: begin
        if (boundary) begin
          state_nxt  = IDLE;
          done_nxt   = 1'b1;
          active_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
        dp_nxt    = 1'b1;
        dm_nxt    = 1'b0;
      end
    endcase
  end

  // State, counters, registered lines and pulses; reset forces IDLE with line J.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      se0_cnt   <= '0;
      d_plus    <= 1'b1;
      d_minus   <= 1'b0;
      tx_active <= 1'b0;
      stuff_bit <= 1'b0;
      eop_done  <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      ones_cnt  <= ones_nxt;
      se0_cnt   <= se0_nxt;
      d_plus    <= dp_nxt;
      d_minus   <= dm_nxt;
      tx_active <= active_nxt;
      stuff_bit <= stuff_nxt;
      eop_done  <= done_nxt;
      tx_err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_usb_tx_nrzi_stuff.sv
// Directed bench for usb_tx_nrzi_stuff: default build plus a 1-clk/3-ones build.
// Inputs change 1ns after the rising edge, outputs are sampled 1-2ns after it.
// Lines are compared as {d_plus,d_minus}: J=10, K=01, SE0=00.
module tb_usb_tx_nrzi_stuff;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam int         BND  = 64;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  usb_tx_nrzi_stuff_if bus_a ();
  usb_tx_nrzi_stuff_if bus_b ();

  logic a_dp, a_dm, a_act, a_stuff, a_done, a_err;
  logic b_dp, b_dm, b_act, b_stuff, b_done, b_err;

  usb_tx_nrzi_stuff u_dut_a (
    .clk       (clk),
    .n_rst     (n_rst),
    .tx        (bus_a),
    .d_plus    (a_dp),
    .d_minus   (a_dm),
    .tx_active (a_act),
    .stuff_bit (a_stuff),
    .eop_done  (a_done),
    .tx_err    (a_err)
  );

  usb_tx_nrzi_stuff #(
    .CLKS_PER_BIT (1),
    .STUFF_LEN    (3),
    .EOP_SE0_BITS (2)
  ) u_dut_b (
    .clk       (clk),
    .n_rst     (n_rst),
    .tx        (bus_b),
    .d_plus    (b_dp),
    .d_minus   (b_dm),
    .tx_active (b_act),
    .stuff_bit (b_stuff),
    .eop_done  (b_done),
    .tx_err    (b_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one bit to DUT A, wait for it to be taken, then check the wait
  // length, stuffed bits seen while waiting, and the new line level.
  task automatic send_bit(input logic b, input logic [1:0] exp_line,
                          input int exp_wait, input int exp_stuffs, input string tag);
    int w = 0;
    int stuffs = 0;
    bus_a.d_orig  = b;
    bus_a.d_valid = 1'b1;
    bus_a.eop_req = 1'b0;
    #1;
    while (bus_a.d_ready !== 1'b1 && w < BND) begin
      @(posedge clk);
      #1;
      w++;
      stuffs += int'(a_stuff);
      #1;
    end
    check({tag, " wait"}, 32'(w), 32'(exp_wait));
    check({tag, " stuffs"}, 32'(stuffs), 32'(exp_stuffs));
    @(posedge clk);
    #1;
    bus_a.d_valid = 1'b0;
    check({tag, " line"}, 32'({a_dp, a_dm}), 32'(exp_line));
    check({tag, " active"}, 32'(a_act), 32'd1);
  endtask

  // Drive the end-of-packet condition on DUT A and follow the EOP to IDLE.
  task automatic do_eop(input logic eop, input logic valid, input int exp_pre,
                        input int exp_stuffs, input logic exp_err, input string tag);
    int   w = 0;
    int   stuffs = 0;
    int   se0 = 1;
    int   jn = 1;
    logic rdy_seen = 1'b0;
    bus_a.eop_req = eop;
    bus_a.d_valid = valid;
    bus_a.d_orig  = 1'b1;
    while (w < BND) begin
      #1;
      rdy_seen = rdy_seen | bus_a.d_ready;
      @(posedge clk);
      #1;
      w++;
      stuffs += int'(a_stuff);
      if (a_dp === 1'b0 && a_dm === 1'b0) break;
    end
    check({tag, " pre cycles"}, 32'(w), 32'(exp_pre));
    check({tag, " ready held low"}, 32'(rdy_seen), 32'd0);
    check({tag, " stuffs"}, 32'(stuffs), 32'(exp_stuffs));
    check({tag, " tx_err at se0"}, 32'(a_err), 32'(exp_err));
    bus_a.eop_req = 1'b0;
    bus_a.d_valid = 1'b0;
    while (se0 < BND) begin
      tick();
      if (!(a_dp === 1'b0 && a_dm === 1'b0)) break;
      se0++;
    end
    check({tag, " se0 clks"}, 32'(se0), 32'd8);
    check({tag, " eop J line"}, 32'({a_dp, a_dm}), 32'(LJ));
    check({tag, " active in J"}, 32'(a_act), 32'd1);
    while (jn < BND) begin
      tick();
      if (a_done === 1'b1) break;
      jn++;
    end
    check({tag, " J clks"}, 32'(jn), 32'd4);
    check({tag, " eop_done"}, 32'(a_done), 32'd1);
    check({tag, " active off"}, 32'(a_act), 32'd0);
    tick();
    check({tag, " eop_done pulse"}, 32'(a_done), 32'd0);
    check({tag, " idle line"}, 32'({a_dp, a_dm}), 32'(LJ));
  endtask

  // DUT B vectors: drive {valid, orig, eop}; expect {ready, dp, dm, stuff, done, active}.
  logic [2:0] b_drv [0:10] = '{3'b100, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110,
                               3'b111, 3'b000, 3'b000, 3'b000, 3'b000};
  logic [5:0] b_exp [0:10] = '{6'b101001, 6'b101001, 6'b101001, 6'b101001,
                               6'b010101, 6'b110001, 6'b000001, 6'b000001,
                               6'b010001, 6'b010010, 6'b010000};

  logic sync_bits [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [1:0] sync_line [0:7] = '{LK, LJ, LK, LJ, LK, LJ, LK, LK};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0;
    bus_a.d_orig = 1'b0; bus_a.d_valid = 1'b0; bus_a.eop_req = 1'b0;
    bus_b.d_orig = 1'b0; bus_b.d_valid = 1'b0; bus_b.eop_req = 1'b0;
    tick();
    tick();
    check("reset line", 32'({a_dp, a_dm}), 32'(LJ));
    check("reset pulses", 32'({a_act, a_stuff, a_done, a_err}), 32'd0);
    check("reset b line", 32'({b_dp, b_dm}), 32'(LJ));
    n_rst = 1'b1;
    tick();

    // SYNC pattern, then eight ones (stuff after the SYNC's trailing one plus five).
    for (int i = 0; i < 8; i++)
      send_bit(sync_bits[i], sync_line[i], (i == 0) ? 0 : 3, 0, $sformatf("sync%0d", i));
    for (int i = 0; i < 8; i++)
      send_bit(1'b1, (i < 5) ? LK : LJ, (i == 5) ? 7 : 3, (i == 5) ? 1 : 0,
               $sformatf("ones%0d", i));
    do_eop(1'b1, 1'b0, 4, 0, 1'b0, "eop plain");

    // Six ones end the packet: the pending stuff goes out before SE0.
    send_bit(1'b0, LK, 0, 0, "p4 first");
    for (int i = 0; i < 6; i++)
      send_bit(1'b1, LK, 3, 0, $sformatf("p4 one%0d", i));
    do_eop(1'b1, 1'b0, 8, 1, 1'b0, "eop stuffed");

    // Underrun aborts with tx_err and a full EOP.
    send_bit(1'b0, LK, 0, 0, "p5 first");
    do_eop(1'b0, 1'b0, 4, 0, 1'b1, "underrun");

    // eop_req beats d_valid.
    send_bit(1'b0, LK, 0, 0, "p6 first");
    do_eop(1'b1, 1'b1, 4, 0, 1'b0, "eop vs valid");

    // Small build: one clock per bit, stuff after three ones.
    for (int i = 0; i < 11; i++) begin
      bus_b.d_valid = b_drv[i][2];
      bus_b.d_orig  = b_drv[i][1];
      bus_b.eop_req = b_drv[i][0];
      #1;
      check($sformatf("b%0d ready", i), 32'(bus_b.d_ready), 32'(b_exp[i][5]));
      @(posedge clk);
      #1;
      check($sformatf("b%0d outs", i), 32'({b_dp, b_dm, b_stuff, b_done, b_act}),
            32'(b_exp[i][4:0]));
      check($sformatf("b%0d err", i), 32'(b_err), 32'd0);
    end

    // Reset wins mid-packet.
    send_bit(1'b0, LK, 0, 0, "rst first");
    send_bit(1'b1, LK, 3, 0, "rst second");
    n_rst = 1'b0;
    tick();
    tick();
    check("mid rst line", 32'({a_dp, a_dm}), 32'(LJ));
    check("mid rst pulses", 32'({a_act, a_stuff, a_done, a_err}), 32'd0);
    n_rst = 1'b1;
    tick();
    tick();
    check("post rst idle", 32'({a_dp, a_dm, a_act}), 32'({LJ, 1'b0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
